mac_cyv_rr_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one `mac_cyv_half_fin` multiply-accumulate pipeline among `NREQ` requesters. Each requester offers one half-float (a, b) pair plus a 32-bit fixed-point addend c; the block grants one request per cycle and drives the MAC inputs from a register stage. A tag pipeline matched to the MAC latency returns each half-float result to its owning requester. A drain state machine empties the shared pipeline before reconfiguration or power-down.

---
 rtl/mac_cyv_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mac_cyv_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_cyv_rr_arbiter.sv
// Round-robin scheduler sharing one MAC among NREQ requesters; response arrives MAC_LATENCY+1 edges after the issue edge.
// Responses have no backpressure; `drain` stops granting until the pipe is empty. `MAC_ARB_STATS_EN` enables grant counters.
module mac_cyv_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int MAC_LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [16*NREQ-1:0]         req_a,
  input  logic [16*NREQ-1:0]         req_b,
  input  logic [32*NREQ-1:0]         req_c,
  output logic                       mac_en,
  output logic [15:0]                mac_a,
  output logic [15:0]                mac_b,
  output logic [31:0]                mac_c,
  input  logic [31:0]                mac_q,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [15:0]                rsp_q,
  input  logic                       drain,
  output logic                       drained,
  output logic                       busy,
  output logic [16*NREQ-1:0]         grant_cnt
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  logic [1:0]     state, state_nx;
  logic [IDW-1:0] last;
  logic [IDW-1:0] issue_id;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] gnt_id;
  logic           found;
  logic           xfer;
  logic [NREQ-1:0] gnt;

  // Stage 0 lines up with the MAC input capture edge, so the last stage meets mac_q.
  logic [MAC_LATENCY:0] tag_v;
  logic [IDW-1:0]       tag_id [MAC_LATENCY+1];

  logic unused_mac_hi;
  assign unused_mac_hi = ^mac_q[31:16];

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    gnt    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last) + off) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    xfer = found && (state == ST_RUN);
    if (xfer) gnt[gnt_id] = 1'b1;
  end

  assign req_ready = gnt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mac_en   <= 1'b0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_c    <= '0;
      issue_id <= '0;
      last     <= IDW'(NREQ - 1);
    end else begin
      mac_en <= xfer;
      if (xfer) begin
        mac_a    <= req_a[16*gnt_id +: 16];
        mac_b    <= req_b[16*gnt_id +: 16];
        mac_c    <= req_c[32*gnt_id +: 32];
        issue_id <= gnt_id;
        last     <= gnt_id;
      end else begin
        mac_a    <= '0;
        mac_b    <= '0;
        mac_c    <= '0;
        issue_id <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tag_v <= '0;
      for (int i = 0; i <= MAC_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= mac_en;
      tag_id[0] <= issue_id;
      for (int i = 1; i <= MAC_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp_valid = tag_v[MAC_LATENCY];
  assign rsp_id    = tag_id[MAC_LATENCY];
  assign rsp_q     = mac_q[15:0];

  // Registered view of what will be in flight after this edge (last stage included).
  always_ff @(posedge clk or posedge areset) begin
    if (areset) busy <= 1'b0;
    else        busy <= xfer | mac_en | (|tag_v[MAC_LATENCY-1:0]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:     if (drain)  state_nx = ST_DRAIN;
      ST_DRAIN:   if (!busy)  state_nx = ST_DRAINED;
      ST_DRAINED: if (!drain) state_nx = ST_RUN;
      default:                state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= ST_RUN;
    else        state <= state_nx;
  end

  assign drained = (state == ST_DRAINED);

`ifdef MAC_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        grant_cnt[16*g +: 16] <= '0;
      end else if (gnt[g] && (grant_cnt[16*g +: 16] != 16'hFFFF)) begin
        grant_cnt[16*g +: 16] <= grant_cnt[16*g +: 16] + 16'd1;
      end
    end
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_cyv_rr_arbiter.sv
// Directed bench for mac_cyv_rr_arbiter with a power-of-two MAC stand-in and a response scoreboard.
module tb_mac_cyv_rr_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic         clk = 1'b0;
  logic         areset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [63:0]  req_a, req_b;
  logic [127:0] req_c;
  logic         mac_en;
  logic [15:0]  mac_a, mac_b;
  logic [31:0]  mac_c, mac_q;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [15:0]  rsp_q;
  logic         drain, drained, busy;
  logic [63:0]  grant_cnt;

  always #5 clk = ~clk;

  mac_cyv_rr_arbiter #(.NREQ(NREQ), .MAC_LATENCY(LAT)) dut (
    .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .mac_en(mac_en), .mac_a(mac_a),
    .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .drain(drain), .drained(drained),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  // MAC stand-in: exact for half-floats with zero mantissa, addend ignored.
  function automatic logic [15:0] pmul(input logic [15:0] a, input logic [15:0] b);
    return {a[15] ^ b[15], a[14:10] + b[14:10] - 5'd15, 10'h000};
  endfunction

  logic [15:0] stub_p [LAT+1];
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i <= LAT; i++) stub_p[i] <= '0;
    end else begin
      stub_p[0] <= mac_en ? pmul(mac_a, mac_b) : 16'h0000;
      for (int i = 1; i <= LAT; i++) stub_p[i] <= stub_p[i-1];
    end
  end
  assign mac_q = {16'h0000, stub_p[LAT]};

  typedef struct {
    logic [1:0]  id;
    logic [15:0] q;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b1;
  logic [15:0] exp_q [4] = '{16'h4000, 16'h4400, 16'h4800, 16'h4C00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_id=%0d rsp_q=%0h with nothing outstanding (cycle %0d)",
                 rsp_id, rsp_q, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_q", 64'(rsp_q), 64'(mon_e.q));
        chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Drive one cycle, check the grant, and book the response it implies.
  task automatic cycle(input logic [3:0] v, input logic d, input logic [3:0] er);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    drain     = d;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(er));
    for (int i = 0; i < NREQ; i++) begin
      if (er[i]) begin
        e.id  = 2'(i);
        e.q   = exp_q[i];
        e.due = cyc + 6;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(4'b0000, 1'b0, 4'b0000);
  endtask

  task automatic reset_checks();
    chk("rst_mac_en", 64'(mac_en), 64'd0);
    chk("rst_mac_abc", {mac_a, mac_b, mac_c}, 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_drained", 64'(drained), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_cnt", grant_cnt, 64'd0);
  endtask

  initial begin
    areset    = 1'b1;
    req_valid = '0;
    drain     = 1'b0;
    req_a = {4{16'h3C00}};
    req_b = {16'h4C00, 16'h4800, 16'h4400, 16'h4000};
    req_c = {32'h0030_0000, 32'h0020_0000, 32'h0018_0000, 32'h0000_0000};
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    reset_checks();
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // single request from requester 0
    cycle(4'b0001, 1'b0, 4'b0001);
    cycle(4'b0000, 1'b0, 4'b0000);
    chk("issue_en", 64'(mac_en), 64'd1);
    chk("issue_ab", {32'h0, mac_a, mac_b}, {32'h0, 16'h3C00, 16'h4000});
    chk("issue_c", 64'(mac_c), 64'd0);
    chk("busy_after_grant", 64'(busy), 64'd1);
    idle(8);

    // park the pointer on 3, then all four compete
    cycle(4'b1000, 1'b0, 4'b1000);
    for (int r = 0; r < 2; r++) begin
      cycle(4'b1111, 1'b0, 4'b0001);
      cycle(4'b1111, 1'b0, 4'b0010);
      cycle(4'b1111, 1'b0, 4'b0100);
      cycle(4'b1111, 1'b0, 4'b1000);
    end
    idle(8);

    // pointer continues from 2
    cycle(4'b0100, 1'b0, 4'b0100);
    cycle(4'b1010, 1'b0, 4'b1000);
    chk("issue_c_req2", 64'(mac_c), 64'h0020_0000);
    cycle(4'b1010, 1'b0, 4'b0010);
    idle(8);

`ifndef MAC_ARB_STATS_EN
    chk("grant_cnt_tied", grant_cnt, 64'd0);
`endif

    // drain on the third grant
    cycle(4'b0001, 1'b0, 4'b0001);
    cycle(4'b0010, 1'b0, 4'b0010);
    cycle(4'b0100, 1'b1, 4'b0100);
    for (int j = 0; j < 10; j++) begin
      cycle(4'b1111, 1'b1, 4'b0000);
      chk($sformatf("drain_busy_%0d", j), 64'(busy), 64'(j <= 5));
      chk($sformatf("drain_drained_%0d", j), 64'(drained), 64'(j >= 7));
    end
    cycle(4'b1111, 1'b0, 4'b0000);
    cycle(4'b1111, 1'b0, 4'b1000);
    chk("undrained", 64'(drained), 64'd0);
    idle(9);

    // reset with two tags in flight
    cycle(4'b0001, 1'b0, 4'b0001);
    cycle(4'b0010, 1'b0, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    areset    = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    reset_checks();
    idle(10);
    cycle(4'b1111, 1'b0, 4'b0001);
    idle(9);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

`ifdef MAC_ARB_STATS_EN
    mon_en = 1'b0;
    @(posedge clk);
    #1 areset = 1'b1;
    @(posedge clk);
    #1;
    areset    = 1'b0;
    req_valid = 4'b0010;
    repeat (70000) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("grant_cnt_sat", grant_cnt, {16'h0000, 16'h0000, 16'hFFFF, 16'h0000});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
